store_buffer: RTL

- Write-posting FIFO between the EX/MEM pipeline register and the data memory in the pipelined processor.
- Stores retire from the pipeline into this buffer in one cycle. The buffer drains them into data memory on cycles when the memory port is not needed by a load.
- Loads are checked against buffered stores. The youngest matching entry's data is forwarded, so a load never returns stale memory contents.
- Owns the memory address/write-data/write-enable mux feeding data memory.

---
 rtl/store_buffer.sv | 112 +++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Write-posting store buffer between EX/MEM and data memory.
// Drains the oldest store when no load needs the port; forwards the youngest matching store to loads.
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    output logic                       st_ready,
    input  logic                       ld_check,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data,
    output logic [ADDR_W-1:0]          dm_addr,
    output logic [DATA_W-1:0]          dm_wData,
    output logic                       dm_MemWrite,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              push;
    logic              drain;
    logic [PTR_W-1:0]  idx;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign st_ready = !full;
    assign push     = st_valid && st_ready;
    // Drain is held off during reset so a pending entry never strobes memory in the reset cycle.
    assign drain    = rst_n && !ld_check && !empty;

    assign dm_MemWrite = drain;
    assign dm_addr     = drain ? addr_q[head_q] : ld_addr;
    assign dm_wData    = drain ? data_q[head_q] : '0;

    // Scan oldest to youngest so the last match found is the youngest.
    always_comb begin
        idx      = head_q;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (addr_q[idx] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign ld_hit  = ld_check && fwd_hit;
    assign ld_data = ld_hit ? fwd_data : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push && !drain) begin
            count_d = count_q + CNT_W'(1);
        end else if (drain && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
    end

endmodule
